// File: rtl/md_pkg.sv
// Shared RV32IM issue-control definitions: opcodes, functional-unit and hazard encodings.
package md_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [6:0] MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_LSU = 2'd1,
    FU_MUL = 2'd2,
    FU_DIV = 2'd3
  } fu_e;

  typedef enum logic [1:0] {
    HZ_NONE   = 2'd0,
    HZ_RAW    = 2'd1,
    HZ_WAW    = 2'd2,
    HZ_STRUCT = 2'd3
  } hazard_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_inst_decode.sv
// Combinational RV32IM decode: source usage, destination, functional unit, latency, legality.
module md_inst_decode
  import md_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned LD_LAT  = 2,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 16,
  parameter int unsigned LW      = 5
) (
  input  logic [31:0]   i_inst,
  output logic [4:0]    o_rs1,
  output logic [4:0]    o_rs2,
  output logic [4:0]    o_rd,
  output logic          o_rs1use,
  output logic          o_rs2use,
  output logic          o_has_rd,
  output fu_e           o_fu,
  output logic [LW-1:0] o_lat,
  output logic          o_illegal
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_rd_wr;

  assign w_opc = i_inst[6:0];
  assign w_f3  = i_inst[14:12];
  assign w_f7  = i_inst[31:25];
  assign o_rs1 = i_inst[19:15];
  assign o_rs2 = i_inst[24:20];
  assign o_rd  = i_inst[11:7];

  always_comb begin
    o_rs1use  = 1'b0;
    o_rs2use  = 1'b0;
    w_rd_wr   = 1'b0;
    o_fu      = FU_ALU;
    o_lat     = LW'(ALU_LAT);
    o_illegal = 1'b0;
    case (w_opc)
      OP: begin
        o_rs1use = 1'b1;
        o_rs2use = 1'b1;
        w_rd_wr  = 1'b1;
        if (w_f7 == MULDIV) begin
          o_fu  = w_f3[2] ? FU_DIV : FU_MUL;
          o_lat = w_f3[2] ? LW'(DIV_LAT) : LW'(MUL_LAT);
        end else if (!(w_f7 == 7'b0000000 ||
                       (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)))) begin
          o_illegal = 1'b1;
        end
      end
      OP_IMM: begin
        o_rs1use = 1'b1;
        w_rd_wr  = 1'b1;
        if ((w_f3 == 3'b001 && w_f7 != 7'b0000000) ||
            (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000))
          o_illegal = 1'b1;
      end
      LOAD: begin
        o_rs1use = 1'b1;
        w_rd_wr  = 1'b1;
        o_fu     = FU_LSU;
        o_lat    = LW'(LD_LAT);
        if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) o_illegal = 1'b1;
      end
      STORE: begin
        o_rs1use = 1'b1;
        o_rs2use = 1'b1;
        o_fu     = FU_LSU;
        o_lat    = LW'(LD_LAT);
        if (w_f3[2] || w_f3 == 3'b011) o_illegal = 1'b1;
      end
      BRANCH: begin
        o_rs1use = 1'b1;
        o_rs2use = 1'b1;
        if (w_f3 == 3'b010 || w_f3 == 3'b011) o_illegal = 1'b1;
      end
      LUI, AUIPC, JAL: w_rd_wr = 1'b1;
      JALR: begin
        o_rs1use = 1'b1;
        w_rd_wr  = 1'b1;
        if (w_f3 != 3'b000) o_illegal = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

  assign o_has_rd = w_rd_wr && (o_rd != 5'd0);

endmodule

// File: rtl/md_issue_ctrl.sv
// Scoreboard issue control for the ID stage: per-register pending counters,
// write-back port reservations and divider occupancy decide issue/stall each cycle.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned NREG    = 32,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned LD_LAT  = 2,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [31:0]     inst_i,
  input  logic            flush_i,
  output logic            issue_o,
  output logic            stall_o,
  output logic [1:0]      hazard_type_o,
  output logic [1:0]      fu_sel_o,
  output logic            illegal_o,
  output logic            wb_valid_o,
  output logic [NREG-1:0] pending_o
);

  localparam int unsigned MAX_LAT = max2(max2(ALU_LAT, LD_LAT), max2(MUL_LAT, DIV_LAT));
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0]      r_cnt [NREG];
  logic [MAX_LAT-1:0] r_wb;
  logic [CW-1:0]      r_div_cnt;

  logic [4:0]         w_rs1, w_rs2, w_rd;
  logic               w_rs1use, w_rs2use, w_has_rd, w_illegal;
  fu_e                w_fu;
  logic [CW-1:0]      w_lat;
  logic [CW-1:0]      w_cnt_rs1, w_cnt_rs2, w_cnt_rd;
  logic [MAX_LAT-1:0] w_slot, w_wb_shift;
  logic               w_chk, w_raw, w_waw, w_struct;
  hazard_e            w_haz;

  md_inst_decode #(
    .ALU_LAT (ALU_LAT),
    .LD_LAT  (LD_LAT),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .LW      (CW)
  ) u_dec (
    .i_inst    (inst_i),
    .o_rs1     (w_rs1),
    .o_rs2     (w_rs2),
    .o_rd      (w_rd),
    .o_rs1use  (w_rs1use),
    .o_rs2use  (w_rs2use),
    .o_has_rd  (w_has_rd),
    .o_fu      (w_fu),
    .o_lat     (w_lat),
    .o_illegal (w_illegal)
  );

  always_comb begin
    w_cnt_rs1 = '0;
    w_cnt_rs2 = '0;
    w_cnt_rd  = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (w_rs1 == 5'(r)) w_cnt_rs1 = r_cnt[r];
      if (w_rs2 == 5'(r)) w_cnt_rs2 = r_cnt[r];
      if (w_rd  == 5'(r)) w_cnt_rd  = r_cnt[r];
    end
  end

  // The new write-back lands L cycles from now, i.e. slot L-1 of the already-shifted vector.
  always_comb begin
    w_slot = '0;
    for (int unsigned k = 0; k < MAX_LAT; k++) w_slot[k] = (w_lat == CW'(k + 1));
  end
  assign w_wb_shift = r_wb >> 1;

  assign w_chk    = valid_i && !flush_i && !w_illegal && !rst;
  assign w_raw    = (w_rs1use && w_cnt_rs1 > CW'(1)) || (w_rs2use && w_cnt_rs2 > CW'(1));
  assign w_waw    = w_has_rd && (w_cnt_rd > w_lat);
  assign w_struct = (w_has_rd && |(w_slot & w_wb_shift)) ||
                    (w_fu == FU_DIV && r_div_cnt > CW'(1));

  always_comb begin
    w_haz = HZ_NONE;
    if (w_chk) begin
      if (w_raw)         w_haz = HZ_RAW;
      else if (w_waw)    w_haz = HZ_WAW;
      else if (w_struct) w_haz = HZ_STRUCT;
    end
  end

  assign stall_o       = (w_haz != HZ_NONE);
  assign issue_o       = w_chk && !stall_o;
  assign hazard_type_o = w_haz;
  assign fu_sel_o      = w_fu;
  assign illegal_o     = w_illegal;
  assign wb_valid_o    = r_wb[0] && !rst;

  always_comb begin
    pending_o = '0;
    for (int unsigned r = 0; r < NREG; r++) pending_o[r] = (r_cnt[r] != '0) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) r_cnt[r] <= '0;
      r_wb      <= '0;
      r_div_cnt <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (issue_o && w_has_rd && w_rd == 5'(r)) r_cnt[r] <= w_lat;
        else if (r_cnt[r] != '0)                  r_cnt[r] <= r_cnt[r] - CW'(1);
      end
      r_wb <= w_wb_shift | ((issue_o && w_has_rd) ? w_slot : '0);
      if (issue_o && w_fu == FU_DIV) r_div_cnt <= CW'(DIV_LAT);
      else if (r_div_cnt != '0)      r_div_cnt <= r_div_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed-vector bench for md_issue_ctrl; driver queues expected responses, monitor checks them.
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst, valid_i, flush_i;
  logic [31:0] inst_i;
  logic        issue_o, stall_o, illegal_o, wb_valid_o;
  logic [1:0]  hazard_type_o, fu_sel_o;
  logic [31:0] pending_o;

  md_issue_ctrl #(
    .NREG    (32),
    .ALU_LAT (1),
    .LD_LAT  (2),
    .MUL_LAT (4),
    .DIV_LAT (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .inst_i        (inst_i),
    .flush_i       (flush_i),
    .issue_o       (issue_o),
    .stall_o       (stall_o),
    .hazard_type_o (hazard_type_o),
    .fu_sel_o      (fu_sel_o),
    .illegal_o     (illegal_o),
    .wb_valid_o    (wb_valid_o),
    .pending_o     (pending_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic        issue;
    logic        stall;
    logic [1:0]  haz;
    logic        wb;
    logic [31:0] pend;
    logic [1:0]  fu;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned cyc_no  = 0;
  bit          drv_done = 1'b0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] rtype(input logic [6:0] f7, input int unsigned rs2,
                                        input int unsigned rs1, input logic [2:0] f3,
                                        input int unsigned rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] addi(input int unsigned rd, input int unsigned rs1,
                                       input logic [11:0] imm);
    return {imm, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction

  function automatic logic [31:0] add(input int unsigned rd, input int unsigned rs1, input int unsigned rs2);
    return rtype(7'b0000000, rs2, rs1, 3'b000, rd);
  endfunction

  function automatic logic [31:0] mul(input int unsigned rd, input int unsigned rs1, input int unsigned rs2);
    return rtype(7'b0000001, rs2, rs1, 3'b000, rd);
  endfunction

  function automatic logic [31:0] div(input int unsigned rd, input int unsigned rs1, input int unsigned rs2);
    return rtype(7'b0000001, rs2, rs1, 3'b100, rd);
  endfunction

  function automatic logic [31:0] P(input int unsigned r);
    return 32'd1 << r;
  endfunction

  task automatic cyc(input logic r, input logic v, input logic f, input logic [31:0] inst,
                     input logic e_iss, input logic e_stall, input logic [1:0] e_haz,
                     input logic e_wb, input logic [31:0] e_pend,
                     input logic [1:0] e_fu, input logic e_ill);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; valid_i = v; flush_i = f; inst_i = inst;
    e.cyc = cyc_no; e.issue = e_iss; e.stall = e_stall; e.haz = e_haz; e.wb = e_wb;
    e.pend = e_pend; e.fu = e_fu; e.ill = e_ill;
    q.push_back(e);
    cyc_no++;
  endtask

  task automatic idle(input logic e_wb, input logic [31:0] e_pend);
    cyc(1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 2'd0, e_wb, e_pend, 2'd0, 1'b0);
  endtask

  task automatic chk(input string name, input int unsigned c, input logic [31:0] act,
                     input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, c, act, req);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("issue",    e.cyc, 32'(issue_o),       32'(e.issue));
        chk("stall",    e.cyc, 32'(stall_o),       32'(e.stall));
        chk("hazard",   e.cyc, 32'(hazard_type_o), 32'(e.haz));
        chk("wb_valid", e.cyc, 32'(wb_valid_o),    32'(e.wb));
        chk("pending",  e.cyc, pending_o,          e.pend);
        chk("fu_ill",   e.cyc, {29'd0, fu_sel_o, illegal_o}, {29'd0, e.fu, e.ill});
      end
    end
  end

  initial begin : driver
    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; inst_i = NOP;

    // reset, including a valid instruction presented while in reset
    cyc(1, 0, 0, NOP,          0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, add(5, 1, 2), 0, 0, 0, 0, 0, 0, 0);

    // dependent ALU chain, no bubbles
    cyc(0, 1, 0, add(5, 1, 2), 1, 0, 0, 0, 0,     0, 0);
    cyc(0, 1, 0, add(6, 5, 3), 1, 0, 0, 1, P(5),  0, 0);
    idle(1, P(6));
    idle(0, 0);

    // MUL RAW: three stall cycles
    cyc(0, 1, 0, mul(5, 1, 2), 1, 0, 0, 0, 0, 2, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, add(6, 5, 0), 0, 1, 1, 0, P(5), 0, 0);
    cyc(0, 1, 0, add(6, 5, 0), 1, 0, 0, 1, P(5), 0, 0);
    idle(1, P(6));
    idle(0, 0);

    // divider structural hazard
    cyc(0, 1, 0, div(7, 1, 2), 1, 0, 0, 0, 0, 3, 0);
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, div(8, 1, 2), 0, 1, 3, 0, P(7), 3, 0);
    cyc(0, 1, 0, div(8, 1, 2), 1, 0, 0, 1, P(7), 3, 0);

    // reset five cycles into the second DIV, new DIV right after
    for (int i = 0; i < 4; i++) idle(0, P(8));
    cyc(1, 1, 0, div(9, 1, 2), 0, 0, 0, 0, 0, 3, 0);
    cyc(0, 1, 0, div(9, 1, 2), 1, 0, 0, 0, 0, 3, 0);
    cyc(1, 0, 0, NOP,          0, 0, 0, 0, 0, 0, 0);

    // WAW behind a DIV
    cyc(0, 1, 0, div(5, 1, 2), 1, 0, 0, 0, 0, 3, 0);
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, addi(5, 0, 12'd1), 0, 1, 2, 0, P(5), 0, 0);
    cyc(0, 1, 0, addi(5, 0, 12'd1), 1, 0, 0, 1, P(5), 0, 0);
    idle(1, P(5));
    idle(0, 0);

    // write-back port conflict
    cyc(0, 1, 0, mul(5, 1, 2), 1, 0, 0, 0, 0, 2, 0);
    idle(0, P(5));
    idle(0, P(5));
    cyc(0, 1, 0, addi(9, 0, 12'd1), 0, 1, 3, 0, P(5), 0, 0);
    cyc(0, 1, 0, addi(9, 0, 12'd1), 1, 0, 0, 1, P(5), 0, 0);
    idle(1, P(9));
    idle(0, 0);

    // write to x0 leaves nothing pending
    cyc(0, 1, 0, addi(0, 0, 12'd1), 1, 0, 0, 0, 0, 0, 0);
    idle(0, 0);

    // flush masks a hazard, then the hazard resumes
    cyc(0, 1, 0, mul(5, 1, 2), 1, 0, 0, 0, 0, 2, 0);
    cyc(0, 1, 1, add(6, 5, 0), 0, 0, 0, 0, P(5), 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 1, 0, add(6, 5, 0), 0, 1, 1, 0, P(5), 0, 0);
    cyc(0, 1, 0, add(6, 5, 0), 1, 0, 0, 1, P(5), 0, 0);
    idle(1, P(6));
    idle(0, 0);

    // illegal instruction: no issue, no stall, no state
    cyc(0, 1, 0, 32'h0000_0000, 0, 0, 0, 0, 0, 0, 1);
    idle(0, 0);

    // store (no rd) and load-use with one stall
    cyc(0, 1, 0, {7'd0, 5'd5, 5'd1, 3'b010, 5'd0, 7'b0100011}, 1, 0, 0, 0, 0, 1, 0);
    idle(0, 0);
    cyc(0, 1, 0, {12'd0, 5'd1, 3'b010, 5'd10, 7'b0000011}, 1, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, add(11, 10, 0), 0, 1, 1, 0, P(10), 0, 0);
    cyc(0, 1, 0, add(11, 10, 0), 1, 0, 0, 1, P(10), 0, 0);
    idle(1, P(11));
    idle(0, 0);

    drv_done = 1'b1;
  end

  initial begin : finisher
    int unsigned guard;
    guard = 0;
    while (!drv_done && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    if (!drv_done) begin
      n_total++;
      $display("FAIL driver_timeout: got %0d cycles, expected completion within 2000", guard);
    end
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: got %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Scoreboard-based issue controller for the ID stage of the pipelined RV32 core, extending decode control to multi-cycle functional units: ALU, LSU, pipelined multiplier and non-pipelined divider (RV32IM). It tracks pending register writes and the single write-back port, and decides each cycle whether the ID instruction may issue. It raises stall and hazard-class signals for the pipeline control logic.

## Interface
- `NREG`, 32: architectural registers tracked; x0 is never pending.
- `ALU_LAT`, 1: ALU, LUI, AUIPC, JAL and JALR latency in cycles.
- `LD_LAT`, 2: load latency.
- `MUL_LAT`, 4: multiplier latency; the multiplier is fully pipelined.
- `DIV_LAT`, 16: divider latency; the divider is non-pipelined.
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  ID holds a valid instruction.
- `inst_i`  in  32  ID instruction word.
- `flush_i`  in  1  kill the ID instruction this cycle.
- `issue_o`  out  1  instruction issues at this clock edge.
- `stall_o`  out  1  hold IF/ID.
- `hazard_type_o`  out  2  0 none, 1 RAW, 2 WAW, 3 structural.
- `fu_sel_o`  out  2  0 ALU, 1 LSU, 2 MUL, 3 DIV.
- `illegal_o`  out  1  undecodable instruction.
- `wb_valid_o`  out  1  a reserved write-back occurs this cycle.
- `pending_o`  out  NREG  per-register pending bit (cnt>0).

## Operation
- **Decode.** Decoding is combinational. It produces rs1use, rs2use, rd, has_rd, fu and latency L.
  - MUL/MULH/MULHSU/MULHU: opcode 0110011, funct7=0000001, funct3 0–3.
  - DIV/DIVU/REM/REMU: same encoding with funct3 4–7.
  - Stores and branches have has_rd=0.
  - has_rd is forced to 0 when rd=x0.
- **State.**
  - Per-register counter cnt[r], width clog2(MAX_LAT+1), where MAX_LAT is the maximum of the latency parameters.
  - Write-back reservation vector R[MAX_LAT-1:0]; R[k] means a write-back occurs k cycles from now.
  - Divider counter div_cnt.
- **Hazard checks** (evaluated only when valid_i & !flush_i & !illegal):
  - RAW: a used source s with cnt[s]>1.
  - WAW: has_rd and cnt[rd]>L, i.e. the older write would land after the new one.
  - Structural:
    - has_rd and R[L-1] set (write-back port conflict), or
    - fu=DIV and div_cnt>1.
- **Result.**
  - stall_o = any hazard.
  - hazard_type_o reports the highest-priority class: RAW > WAW > structural.
  - issue_o = valid_i & !flush_i & !illegal & !stall_o.
- **Illegal instruction.** illegal_o=1, issue_o=0, stall_o=0, no state change.
- **Flush.** flush_i forces issue_o=0 and stall_o=0. It never cancels already-issued operations.
- **Update at every edge** (rst has priority):
  - Every nonzero cnt decrements.
  - R shifts: R[k] <= R[k+1]; the top bit fills with 0.
  - div_cnt decrements if nonzero.
  - On issue with has_rd: cnt[rd] <= L, overriding the decrement, and R[L-1] is set in the shifted vector.
  - On issue of DIV: div_cnt <= DIV_LAT.
- **Register counter semantics.**
  - An instruction issued in cycle t with latency L writes back in cycle t+L, when cnt==1 and R[0]=1.
  - The RF is write-first, so a dependent may issue in that same cycle.
- **Outputs.** wb_valid_o = R[0]. pending_o[r] = (cnt[r]!=0).

## Timing
- **Reset.** All cnt, R and div_cnt are 0. issue_o, stall_o, hazard_type_o, wb_valid_o and pending_o are 0 during and after reset. fu_sel_o and illegal_o follow decode.
- **rst mid-operation.** All in-flight tracking is dropped in the next cycle; no residual stalls.
- **Decision paths.** issue_o, stall_o and hazard_type_o are combinational from inst_i and the current state. State effect appears one edge later.
- **Back-to-back behaviour.**
  - Dependent ALU ops issue back-to-back with zero bubbles.
  - A consumer of an op with latency L sees L-1 stall cycles.
- **Same-cycle events.** Issue in the same cycle as a write-back to the same rd is legal: cnt is reloaded and the old write-back still occurs.
- **Counter wrap.** Counters saturate at 0 and never wrap.

## Structure
- **Shared package `md_pkg`:**
  - Opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR).
  - funct7 constant MULDIV = 7'b0000001.
  - fu_e enum: ALU, LSU, MUL, DIV.
  - hazard_e enum: NONE, RAW, WAW, STRUCT.
- **Sub-module `md_inst_decode`:** combinational. Maps inst_i to rs1use, rs2use, rd, has_rd, fu, L and illegal. Shared with later issue logic.

## Test plan
- **Reset.** Reset mid-DIV (issued at t=0, rst at t=5) → pending_o=0, wb_valid_o=0 and stall_o=0 from t=6; a new DIV issues at t=6.
- **ALU chain.** `add x5,x1,x2` at t, then `add x6,x5,x3` at t+1 → issue_o=1 both cycles, no stall.
- **MUL RAW.** `mul x5,x1,x2` at t, then `add x6,x5,x0` → stall_o=1 with hazard_type_o=1 for t+1..t+3; issues at t+4; wb_valid_o=1 at t+4.
- **Divider structural.** `div x7` at t, then independent `div x8` → hazard_type_o=3 for t+1..t+15; issues at t+16.
- **Write-back conflict.** `mul x5` at t, then `addi x9,x0,1` at t+3 → 1-cycle stall with hazard_type_o=3; issues at t+4 with write-back at t+5.
- **WAW and x0.**
  - `div x5` at t, then `addi x5,x0,1` → hazard_type_o=2 until cnt[x5]≤1; issues at t+16.
  - Writes to x0 never set pending_o[0].
